// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown sequencing controller.
package countdown_pkg;

  localparam int DEFAULT_DIV        = 50_000_000;
  localparam int DEFAULT_ALARM_SECS = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_EXPIRED = 3'd5
  } state_t;

  // Higher code wins when several buttons rise together: load > stop > start.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_START = 2'd1,
    EV_STOP  = 2'd2,
    EV_LOAD  = 2'd3
  } btn_event_t;

  function automatic btn_event_t pick_event(input logic load_ev,
                                            input logic stop_ev,
                                            input logic start_ev);
    if (load_ev)       return EV_LOAD;
    else if (stop_ev)  return EV_STOP;
    else if (start_ev) return EV_START;
    else               return EV_NONE;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second tick; wrap is high in the last cycle of each second.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_reg;
  logic         at_last;

  assign at_last = (count_reg == LAST);
  assign wrap    = en & ~clr & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= at_last ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Button-driven sequencer for the BCD countdown: load/count strobes, expiry detection, timed alarm.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int DIV        = DEFAULT_DIV,
  parameter int ALARM_SECS = DEFAULT_ALARM_SECS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       load_btn,
  input  logic       timer_zero,
  output logic       one_sec,
  output logic       reconfig_bit,
  output logic       alarm,
  output logic       running,
  output logic [2:0] state_o
);

  localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  state_t      state_reg;
  logic [AW-1:0] alarm_cnt_reg;
  logic        start_q, stop_q, load_q;
  btn_event_t  ev;
  logic        presc_en, presc_clr, presc_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      start_q <= start_btn;
      stop_q  <= stop_btn;
      load_q  <= load_btn;
    end
  end

  assign ev = pick_event(load_btn & ~load_q, stop_btn & ~stop_q, start_btn & ~start_q);

  // Fresh count from ARMED or fresh alarm window; PAUSE->RUN keeps the partial second.
  assign presc_en  = (state_reg == ST_RUN) || (state_reg == ST_EXPIRED);
  assign presc_clr = ((state_reg == ST_RUN) && timer_zero) ||
                     ((state_reg == ST_ARMED) && (ev == EV_START) && !timer_zero);

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .wrap (presc_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      alarm_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (ev == EV_LOAD) state_reg <= ST_LOAD;
        ST_LOAD: state_reg <= ST_ARMED;
        ST_ARMED: begin
          if (ev == EV_LOAD)                        state_reg <= ST_LOAD;
          else if (ev == EV_STOP)                   state_reg <= ST_IDLE;
          else if (ev == EV_START && !timer_zero)   state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (timer_zero) begin
            state_reg     <= ST_EXPIRED;
            alarm_cnt_reg <= '0;
          end else if (ev == EV_STOP) begin
            state_reg <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (ev == EV_LOAD)       state_reg <= ST_LOAD;
          else if (ev == EV_STOP)  state_reg <= ST_IDLE;
          else if (ev == EV_START) state_reg <= ST_RUN;
        end
        ST_EXPIRED: begin
          if (ev == EV_LOAD)       state_reg <= ST_LOAD;
          else if (ev == EV_STOP)  state_reg <= ST_IDLE;
          else if (presc_wrap) begin
            if (alarm_cnt_reg == ALARM_LAST) state_reg <= ST_IDLE;
            else                             alarm_cnt_reg <= alarm_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign one_sec      = (state_reg == ST_RUN) & presc_wrap & ~timer_zero;
  assign reconfig_bit = (state_reg == ST_LOAD);
  assign alarm        = (state_reg == ST_EXPIRED);
  assign running      = (state_reg == ST_RUN);
  assign state_o      = state_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl with DIV=4, ALARM_SECS=2 and a behavioural digit-pair model.
module tb_countdown_ctrl;

  localparam int DIV        = 4;
  localparam int ALARM_SECS = 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_ARMED = 3'd2,
                         S_RUN  = 3'd3, S_PAUSE = 3'd4, S_EXP = 3'd5;

  logic clk = 1'b0, rst = 1'b0;
  logic start_btn = 1'b0, stop_btn = 1'b0, load_btn = 1'b0;
  logic timer_zero;
  logic one_sec, reconfig_bit, alarm, running;
  logic [2:0] state_o;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] dp_cnt = 4'd0;
  logic [3:0] preset = 4'd3;
  logic [2:0] prev_st = 3'd0;

  typedef struct {
    int         c;
    logic [2:0] st;
    logic       os, rc, al, rn;
  } exp_t;
  exp_t sb[$];

  countdown_ctrl #(.DIV(DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .load_btn     (load_btn),
    .timer_zero   (timer_zero),
    .one_sec      (one_sec),
    .reconfig_bit (reconfig_bit),
    .alarm        (alarm),
    .running      (running),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Digit-pair model: load preset, count down on one_sec, flag zero.
  always @(posedge clk) begin
    if (reconfig_bit)                 dp_cnt <= preset;
    else if (one_sec && dp_cnt != 0)  dp_cnt <= dp_cnt - 4'd1;
  end
  assign timer_zero = (dp_cnt == 4'd0);

  // Monitor: any state change or strobe is an observation and must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    logic obs;
    obs = (state_o != prev_st) || one_sec || reconfig_bit;
    prev_st = state_o;
    if (obs) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_obs cyc=%0d st=%0d os=%0b rc=%0b al=%0b rn=%0b, required no activity",
                 cyc, state_o, one_sec, reconfig_bit, alarm, running);
      end else begin
        e = sb.pop_front();
        if (e.c != cyc || e.st != state_o || e.os != one_sec || e.rc != reconfig_bit ||
            e.al != alarm || e.rn != running) begin
          n_fail++;
          $display("FAIL obs got cyc=%0d st=%0d os=%0b rc=%0b al=%0b rn=%0b, required cyc=%0d st=%0d os=%0b rc=%0b al=%0b rn=%0b",
                   cyc, state_o, one_sec, reconfig_bit, alarm, running,
                   e.c, e.st, e.os, e.rc, e.al, e.rn);
        end else begin
          $display("obs cyc=%0d st=%0d os=%0b rc=%0b ok", cyc, state_o, one_sec, reconfig_bit);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input int c, input logic [2:0] st, input logic os, input logic rc);
    exp_t e;
    e.c = c; e.st = st; e.os = os; e.rc = rc;
    e.al = (st == S_EXP);
    e.rn = (st == S_RUN);
    sb.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({one_sec, reconfig_bit, alarm, running, state_o} != 7'd0) begin
      n_fail++;
      $display("FAIL %s got os=%0b rc=%0b al=%0b rn=%0b st=%0d, required all 0",
               tag, one_sec, reconfig_bit, alarm, running, state_o);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] st);
    n_checks++;
    if (state_o != st || running != (st == S_RUN)) begin
      n_fail++;
      $display("FAIL %s got st=%0d rn=%0b, required st=%0d rn=%0b",
               tag, state_o, running, st, (st == S_RUN));
    end
  endtask

  // Load from IDLE/ARMED/PAUSE/EXPIRED; ends in the first ARMED cycle.
  task automatic do_load(input logic [3:0] pst, input logic with_start);
    int b;
    b = cyc;
    preset = pst;
    load_btn = 1'b1;
    if (with_start) start_btn = 1'b1;
    expect_obs(b + 1, S_LOAD, 1'b0, 1'b1);
    expect_obs(b + 2, S_ARMED, 1'b0, 1'b0);
    step(1);
    load_btn = 1'b0;
    start_btn = 1'b0;
    step(1);
  endtask

  // Start press; returns the first RUN cycle and ends inside it.
  task automatic do_start(output int r);
    r = cyc + 1;
    start_btn = 1'b1;
    expect_obs(r, S_RUN, 1'b0, 1'b0);
    step(1);
    start_btn = 1'b0;
  endtask

  initial begin
    int r;
    exp_t e;

    rst = 1'b1;
    step(1);
    check_outputs_zero("reset_state");
    step(2);
    rst = 1'b0;
    step(2);

    // 1: full count of 3, expiry, 8-cycle alarm, back to IDLE
    do_load(4'd3, 1'b0);
    do_start(r);
    expect_obs(r + 3,  S_RUN, 1'b1, 1'b0);
    expect_obs(r + 7,  S_RUN, 1'b1, 1'b0);
    expect_obs(r + 11, S_RUN, 1'b1, 1'b0);
    expect_obs(r + 13, S_EXP, 1'b0, 1'b0);
    expect_obs(r + 21, S_IDLE, 1'b0, 1'b0);
    step(25);

    // 2: pause after 2 RUN cycles, resume keeps the partial second
    do_load(4'd3, 1'b0);
    do_start(r);
    step(1);
    stop_btn = 1'b1;
    expect_obs(r + 2, S_PAUSE, 1'b0, 1'b0);
    step(1);
    stop_btn = 1'b0;
    step(10);
    do_start(r);
    expect_obs(r + 1, S_RUN, 1'b1, 1'b0);
    step(2);
    stop_btn = 1'b1;
    expect_obs(r + 3, S_PAUSE, 1'b0, 1'b0);
    step(1);
    stop_btn = 1'b0;
    step(1);

    // 3: load and start together in PAUSE, load wins
    do_load(4'd3, 1'b1);
    check_state("pause_load_start", S_ARMED);

    // 4: start in ARMED with the count already zero is ignored
    do_load(4'd0, 1'b0);
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(20);
    check_state("armed_zero_start", S_ARMED);

    // 5: held start gives one RUN entry; stop in RUN pauses; stop in EXPIRED clears
    do_load(4'd9, 1'b0);
    r = cyc + 1;
    start_btn = 1'b1;
    expect_obs(r, S_RUN, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) expect_obs(r + 3 + 4 * k, S_RUN, 1'b1, 1'b0);
    step(20);
    start_btn = 1'b0;
    stop_btn = 1'b1;
    expect_obs(r + 20, S_PAUSE, 1'b0, 1'b0);
    step(1);
    stop_btn = 1'b0;
    do_load(4'd1, 1'b0);
    do_start(r);
    expect_obs(r + 3, S_RUN, 1'b1, 1'b0);
    expect_obs(r + 5, S_EXP, 1'b0, 1'b0);
    step(7);
    stop_btn = 1'b1;
    expect_obs(r + 8, S_IDLE, 1'b0, 1'b0);
    step(1);
    stop_btn = 1'b0;
    step(3);

    // 6: asynchronous reset mid-RUN and mid-EXPIRED
    do_load(4'd3, 1'b0);
    do_start(r);
    step(2);
    #1 rst = 1'b1;
    #1 check_outputs_zero("rst_mid_run");
    expect_obs(r + 2, S_IDLE, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(10);
    check_state("idle_start_ignored", S_IDLE);

    do_load(4'd1, 1'b0);
    do_start(r);
    expect_obs(r + 3, S_RUN, 1'b1, 1'b0);
    expect_obs(r + 5, S_EXP, 1'b0, 1'b0);
    step(6);
    #1 rst = 1'b1;
    #1 check_outputs_zero("rst_mid_expired");
    expect_obs(r + 6, S_IDLE, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(2);

    do_load(4'd1, 1'b0);
    do_start(r);
    expect_obs(r + 3,  S_RUN, 1'b1, 1'b0);
    expect_obs(r + 5,  S_EXP, 1'b0, 1'b0);
    expect_obs(r + 13, S_IDLE, 1'b0, 1'b0);
    step(16);

    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_obs got nothing, required cyc=%0d st=%0d os=%0b rc=%0b",
               e.c, e.st, e.os, e.rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the two-digit BCD countdown datapath. It turns the user's start, stop and load buttons into the datapath control strobes: the load strobe (`reconfig_bit`) and the one-second count strobe (`one_sec`). It owns the clock prescaler that generates the one-second tick, and it detects expiry from the datapath's zero flag. It then drives a timed alarm and returns to idle. It sits between the button/switch front end and the digit chain; `one_sec` feeds `one_sec_ip`, `reconfig_bit` feeds `reconfig_bit`, and `timer_zero` comes from `DNB_op_1s` of the least-significant pair.

## Interface
- `DIV` — default 50_000_000 — clk cycles per second tick; legal range ≥ 2.
- `ALARM_SECS` — default 5 — seconds the alarm stays asserted after expiry; legal range ≥ 1.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous and active-high.
- `start_btn`  in  1  start/resume request; level, synchronous to `clk`.
- `stop_btn`  in  1  pause/cancel request; level, synchronous to `clk`.
- `load_btn`  in  1  load request; level, synchronous to `clk`.
- `timer_zero`  in  1  high when the whole datapath count is zero.
- `one_sec`  out  1  single-cycle count strobe.
- `reconfig_bit`  out  1  single-cycle datapath load strobe.
- `alarm`  out  1  high while the state is EXPIRED.
- `running`  out  1  high while the state is RUN.
- `state_o`  out  3  current state code.

## Operation
- **Button events.**
  - Each button is registered; an event is `btn & ~btn_q`, i.e. one event per rising edge.
  - Holding a button produces no further events.
  - Event priority is load > stop > start; only the highest-priority event present is acted on.
- **State codes.** IDLE=0, LOAD=1, ARMED=2, RUN=3, PAUSE=4, EXPIRED=5. Codes 6–7 are illegal and go to IDLE.
- **Transitions.**
  - IDLE: load → LOAD; start and stop are ignored.
  - LOAD: lasts exactly one cycle with `reconfig_bit`=1, then ARMED.
  - ARMED:
    - load → LOAD.
    - start with `timer_zero`=0 → RUN, clearing the prescaler to 0.
    - start with `timer_zero`=1 is ignored.
    - stop → IDLE.
  - RUN:
    - `timer_zero`=1 → EXPIRED. This is checked before events, so expiry beats stop.
    - Otherwise stop → PAUSE. Load is ignored in RUN.
  - PAUSE:
    - load → LOAD.
    - start → RUN; the prescaler is kept, so a partial second resumes where it left off.
    - stop → IDLE.
  - EXPIRED:
    - load → LOAD.
    - stop → IDLE (early alarm clear).
    - After `ALARM_SECS` prescaler wraps → IDLE.
- **Prescaler.**
  - Counter width is clog2(DIV).
  - Increments only in RUN and EXPIRED; it is cleared to 0 on entry to EXPIRED and on ARMED→RUN.
  - Wraps from DIV-1 to 0.
- **`one_sec`.** Equals (state==RUN) & (presc==DIV-1) & ~`timer_zero`.
- **Alarm counter.**
  - Width is clog2(ALARM_SECS+1).
  - Counts prescaler wraps while in EXPIRED.
  - Cleared on entering EXPIRED.

## Timing
- **Reset values.** All outputs 0, state IDLE, prescaler 0, alarm counter 0, button registers 0.
- **Button latency.** A button rising at edge k produces an event during cycle k, and the state changes at edge k+1.
- **First tick.** After entering RUN from ARMED, the first `one_sec` is high in the DIV-th RUN cycle; subsequent ticks come every DIV cycles.
- **Expiry.**
  - The datapath updates at the edge ending the tick cycle.
  - `timer_zero` rises in the following cycle.
  - EXPIRED is entered one edge later, with no further ticks.
- **Alarm duration.** `alarm` is high for exactly ALARM_SECS×DIV cycles unless stop or load arrives.
- **`reconfig_bit`.** High for exactly one cycle per load and never concurrently with `one_sec`.
- **Reset mid-operation.** Outputs drop immediately (asynchronously). Datapath contents are not touched by this block.

## Structure
- **Package `countdown_pkg`.** Holds the state enumeration and codes, the button event priority constant order, and the default `DIV`/`ALARM_SECS` values.
- **Sub-module `tick_prescaler`.** Ports: clk, rst, en, clr, wrap. The FSM instantiates it once and shares it between RUN and EXPIRED.
- **Rest of the block.** The edge detectors, FSM and alarm counter live in `countdown_ctrl`.

## Test plan
All scenarios use DIV=4 and ALARM_SECS=2, with a behavioural datapath model (preset 03, decrement on `one_sec`, `timer_zero` when 0).

1. Load pulse, then start → `reconfig_bit` high for 1 cycle. `one_sec` fires at RUN cycles 4, 8 and 12. `timer_zero` rises at cycle 13. EXPIRED is entered at cycle 14, `alarm` stays high 8 cycles, then the state is IDLE.
2. Stop after 2 RUN cycles, idle 10 cycles, then start → PAUSE holds with no ticks. The first tick after resume is the 2nd RUN cycle.
3. In PAUSE, load and start rise in the same cycle → LOAD entered, `reconfig_bit`=1, then ARMED, and `running` stays 0.
4. Start in ARMED with `timer_zero`=1 → state stays 2 and no `one_sec` appears for 20 cycles.
5. Hold `start_btn` high for 20 cycles, then raise stop during RUN → exactly one RUN entry, then PAUSE. Stop in EXPIRED → IDLE next edge with `alarm`=0.
6. Assert `rst` asynchronously mid-RUN and mid-EXPIRED → all outputs 0 before the next edge, `state_o`=0, and the next tick requires a full reload/start sequence.
